// File: rtl/pwm_from_counter.sv
// pwm_from_counter: registered PWM comparator on an upstream count bus with a double-buffered duty updated at period start
module pwm_from_counter #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] i_cnt_in,
  input  logic         i_enable,
  input  logic [N:0]   i_duty_in,
  input  logic         i_duty_valid,
  output logic         o_duty_ready,
  output logic         o_pwm_out,
  output logic         o_period_tick,
  output logic         o_duty_loaded
);
  localparam logic [N:0] DUTY_MAX = {1'b1, {N{1'b0}}};
  logic [N:0] r_active_duty;
  logic [N:0] r_pending_duty;
  logic       r_pending_full;
  logic       r_pwm;
  logic       r_tick;
  logic       r_loaded;
  logic       w_period_start;
  logic       w_accept;
  logic       w_transfer;
  logic [N:0] w_duty_clamped;
  logic [N:0] w_duty_eff;
  // A pending duty moves to active exactly at count 0 so the new period starts with the new duty
  always_comb begin
    w_period_start = i_cnt_in == '0;
    w_accept       = i_duty_valid && !r_pending_full;
    w_transfer     = w_period_start && r_pending_full;
    w_duty_clamped = (i_duty_in > DUTY_MAX) ? DUTY_MAX : i_duty_in;
    w_duty_eff     = w_transfer ? r_pending_duty : r_active_duty;
  end
  // Duty buffers, handshake flag and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_active_duty  <= '0;
      r_pending_duty <= '0;
      r_pending_full <= 1'b0;
      r_pwm          <= 1'b0;
      r_tick         <= 1'b0;
      r_loaded       <= 1'b0;
    end else begin
      if (w_transfer) r_active_duty <= r_pending_duty;
      if (w_accept) r_pending_duty <= w_duty_clamped;
      r_pending_full <= w_accept ? 1'b1 : (w_transfer ? 1'b0 : r_pending_full);
      r_pwm          <= i_enable && ({1'b0, i_cnt_in} < w_duty_eff);
      r_tick         <= w_period_start;
      r_loaded       <= w_transfer;
    end
  end
  assign o_duty_ready  = !r_pending_full;
  assign o_pwm_out     = r_pwm;
  assign o_period_tick = r_tick;
  assign o_duty_loaded = r_loaded;
endmodule

// File: tb/tb_pwm_from_counter.sv
// tb_pwm_from_counter: scoreboard bench with a queue-based duty model, directed scenarios and random traffic
module tb_pwm_from_counter;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] cnt_in = '0;
  logic       enable = 1'b0;
  logic [4:0] duty_in = '0;
  logic       duty_valid = 1'b0;
  logic       duty_ready, pwm_out, period_tick, duty_loaded;
  typedef struct packed {logic pwm; logic tick; logic ld; logic rdy;} exp_t;
  exp_t       sb[$];
  int         pend[$];
  int         act = 0;
  logic [3:0] cnt_n = '0;
  logic       acc = 1'b0;
  int         tests = 0;
  int         fails = 0;
  pwm_from_counter #(.N(4)) dut (
    .clk(clk), .reset(reset), .i_cnt_in(cnt_in), .i_enable(enable),
    .i_duty_in(duty_in), .i_duty_valid(duty_valid), .o_duty_ready(duty_ready),
    .o_pwm_out(pwm_out), .o_period_tick(period_tick), .o_duty_loaded(duty_loaded)
  );
  always #5 clk = ~clk;
  task automatic check(input string n, input logic a, input logic e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %0b expected %0b at %0t", n, a, e, $time);
    end
  endtask
  // Monitor: every registered output set is compared against the next scoreboard entry
  always @(negedge clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("pwm_out", pwm_out, e.pwm);
      check("period_tick", period_tick, e.tick);
      check("duty_loaded", duty_loaded, e.ld);
      check("duty_ready", duty_ready, e.rdy);
    end
  end
  task automatic cyc(input logic v, input logic [4:0] d, input logic en, input logic r);
    exp_t e;
    int   c;
    logic ld;
    @(negedge clk);
    #1;
    reset = r;
    cnt_in = r ? 4'd0 : cnt_n;
    enable = en;
    duty_valid = v;
    duty_in = d;
    c = int'(cnt_in);
    cnt_n = r ? 4'd0 : cnt_n + 4'd1;
    if (r) begin
      act = 0;
      pend.delete();
      acc = 1'b0;
      e = '{pwm: 1'b0, tick: 1'b0, ld: 1'b0, rdy: 1'b1};
    end else begin
      acc = v && pend.size() == 0;
      ld = c == 0 && pend.size() > 0;
      if (ld) act = pend.pop_front();
      if (acc) pend.push_back(d > 5'd16 ? 16 : int'(d));
      e = '{pwm: en && c < act, tick: c == 0, ld: ld, rdy: pend.size() == 0};
    end
    sb.push_back(e);
    if (r) begin
      #1;
      check("reset_immediate_pwm", pwm_out, 1'b0);
      check("reset_immediate_ready", duty_ready, 1'b1);
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 5'd0, 1'b1, 1'b0);
  endtask
  task automatic idle_until(input logic [3:0] k);
    for (int i = 0; i < 16 && cnt_n != k; i++) cyc(1'b0, 5'd0, 1'b1, 1'b0);
  endtask
  task automatic write(input logic [4:0] d);
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) cyc(1'b1, d, 1'b1, 1'b0);
    check("write_accept_timeout", acc, 1'b1);
  endtask
  initial begin
    logic       hold;
    logic [4:0] hd;
    #2;
    check("reset_pwm", pwm_out, 1'b0);
    check("reset_tick", period_tick, 1'b0);
    check("reset_loaded", duty_loaded, 1'b0);
    check("reset_ready", duty_ready, 1'b1);
    cyc(1'b0, 5'd0, 1'b1, 1'b1);
    idle(34);
    idle_until(4'd7);
    write(5'd4);
    idle(40);
    foreach (pend[i]) check("pending_drained", 1'b0, 1'b1);
    idle_until(4'd5);
    write(5'd0);
    idle(36);
    write(5'd16);
    idle(36);
    write(5'd31);
    idle(36);
    idle_until(4'd9);
    write(5'd3);
    write(5'd9);
    idle(50);
    idle_until(4'd0);
    write(5'd6);
    idle(40);
    write(5'd8);
    idle(20);
    idle_until(4'd2);
    for (int i = 0; i < 4; i++) cyc(1'b0, 5'd0, 1'b0, 1'b0);
    idle(20);
    idle_until(4'd6);
    write(5'd12);
    idle(2);
    cyc(1'b0, 5'd0, 1'b1, 1'b1);
    idle(20);
    write(5'd5);
    idle(40);
    hold = 1'b0;
    hd = '0;
    for (int i = 0; i < 2000; i++) begin
      if (!hold) hd = 5'($urandom_range(0, 31));
      hold = hold || $urandom_range(0, 3) == 0;
      cyc(hold, hd, $urandom_range(0, 7) != 0, $urandom_range(0, 299) == 0);
      if (acc || reset) hold = 1'b0;
    end
    cyc(1'b0, 5'd0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size() == 0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/pwm_from_counter.md
# pwm_from_counter

Registered PWM generator that consumes the count bus of the upstream free-running N-bit synchronous counter and compares it against a double-buffered duty value. Duty updates arrive over a valid/ready handshake and take effect only at a period boundary (count == 0), so no glitched or truncated pulses occur. Sits directly downstream of the counter. Drives pwm_out to the pad/LED logic and period_tick to any logic that needs a per-period strobe.

## Interface
- N, 4: width of the upstream count bus; period = 2^N clk cycles.
- clk  in  1  system clock, rising-edge; same clock as the upstream counter.
- reset  in  1  asynchronous, active-high; clock clk.
- cnt_in  in  N  count value from the upstream counter; increments by 1 per clk, wraps 2^N-1 -> 0.
- enable  in  1  1 = PWM output active; 0 = pwm_out forced low.
- duty_in  in  N+1  requested high time in cycles, 0..2^N; larger values clamp to 2^N.
- duty_valid  in  1  duty_in valid this cycle.
- duty_ready  out  1  pending slot empty; a transfer occurs when duty_valid && duty_ready.
- pwm_out  out  1  registered PWM output.
- period_tick  out  1  registered one-cycle pulse per period.
- duty_loaded  out  1  registered one-cycle pulse when a pending duty becomes active.

## Operation
- State: active_duty (N+1 bits), pending_duty (N+1 bits), pending_full (1 bit), plus output flops.
- period_start = (cnt_in == 0). This is combinational and used internally only.
- Clamp: the accepted value is min(duty_in, 2^N), stored in pending_duty. pending_full is then set.
- duty_ready = !pending_full. It is combinational from the flag, so no new write is accepted while a value is pending.
- Transfer: on period_start with pending_full = 1:
  - active_duty <= pending_duty;
  - pending_full <= 0;
  - duty_loaded <= 1 for one cycle.
- duty_eff = (period_start && pending_full) ? pending_duty : active_duty. The new duty applies from count 0 of the new period.
- pwm_out <= enable && ({1'b0,cnt_in} < duty_eff). The compare is N+1 bits wide and unsigned:
  - duty 0 gives an always-low output;
  - duty 2^N gives an always-high output.
- period_tick <= period_start.
- Simultaneous accept and period_start: this is only possible when pending_full = 0. The value is accepted into pending and is NOT bypassed. It takes effect at the next period_start.
- enable deassert: pwm_out goes 0 on the next clk. Handshake, transfer and period_tick keep operating.
- Reset mid-operation:
  - all state clears immediately;
  - any pending write is lost;
  - the first duty accepted afterwards takes effect at the first subsequent cnt_in == 0.

## Timing
- Reset values:
  - pwm_out = 0, period_tick = 0, duty_loaded = 0;
  - active_duty = 0, pending_full = 0, so duty_ready = 1.
- Latency: every output is 1 clk behind the cnt_in value that produced it.
- period_tick is high in the cycle after cnt_in == 0, i.e. while cnt_in == 1.
- pwm_out high duration per period = active_duty cycles, exactly, when enable is steady.
- Handshake:
  - duty_valid may be held until duty_ready; duty_in must be stable while duty_valid && !duty_ready;
  - the transfer cycle is the clk edge where both are high, and duty_ready drops on the following cycle.
- Maximum update rate: one duty change per period.
- Upstream count after reset is 0. That is a valid period_start, and period_tick pulses in the first cycle after reset release.

## Test plan
- Reset then idle, N=4: pwm_out stays 0, duty_ready = 1, period_tick pulses every 16 cycles starting 1 cycle after cnt_in = 0.
- Write duty 4 mid-period (cnt_in = 7):
  - duty_ready drops next cycle;
  - at cnt_in = 0, duty_loaded pulses;
  - pwm_out is high for exactly 4 cycles, while cnt_in = 1..4;
  - duty_ready returns to 1.
- Duty boundaries: duty 0 gives pwm_out constant 0. Duty 16 gives constant 1 over a full period. Duty 31 clamps to 16, also constant 1.
- Back-to-back writes 3 then 9 with duty_valid held:
  - 9 stalls until the transfer of 3;
  - period k has 3 high cycles, period k+1 has 9.
- Write accepted in the same cycle as cnt_in = 0: no duty_loaded that cycle. The new duty applies one full period later.
- enable low for cnt_in = 2..5 with duty 8: pwm_out is 0 at cycles with cnt_in 3..6. Assert reset mid-period: pwm_out = 0 immediately and pending is cleared.
